alu_issue: RTL and testbench

- Decode/issue and writeback stage directly upstream of the combinational `alu` in the 16-bit core.
- Accepts one 16-bit instruction per cycle over a valid/ready handshake and reads the 16x16 register file.
- Registers the operands and drives `alu` dst/src/oper/func/cond. It feeds the PSR into `condIn` and writes `result` and `condOut` back.
- Load/store ops are handed to a memory port and stall the stage until completion.

---
 rtl/isa_pkg.sv | 75 +++++++
 rtl/regfile16x16.sv | 29 ++
 rtl/alu_issue.sv | 150 +++++++++++++++
 tb/tb_alu_issue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode, function-code and PSR definitions shared by the 16-bit core
package isa_pkg;

  typedef enum logic [3:0] {
    OP_REG     = 4'b0000,
    OP_ANDI    = 4'b0001,
    OP_ORI     = 4'b0010,
    OP_XORI    = 4'b0011,
    OP_SPECIAL = 4'b0100,
    OP_ADDI    = 4'b0101,
    OP_ADDUI   = 4'b0110,
    OP_ADDCI   = 4'b0111,
    OP_SHIFT   = 4'b1000,
    OP_SUBI    = 4'b1001,
    OP_SUBCI   = 4'b1010,
    OP_CMPI    = 4'b1011,
    OP_BCOND   = 4'b1100,
    OP_MOVI    = 4'b1101,
    OP_MULI    = 4'b1110,
    OP_LUI     = 4'b1111
  } oper_e;

  localparam logic [3:0] F_AND  = 4'b0001;
  localparam logic [3:0] F_OR   = 4'b0010;
  localparam logic [3:0] F_XOR  = 4'b0011;
  localparam logic [3:0] F_ADD  = 4'b0101;
  localparam logic [3:0] F_ADDU = 4'b0110;
  localparam logic [3:0] F_ADDC = 4'b0111;
  localparam logic [3:0] F_SUB  = 4'b1001;
  localparam logic [3:0] F_SUBC = 4'b1010;
  localparam logic [3:0] F_CMP  = 4'b1011;
  localparam logic [3:0] F_MOV  = 4'b1101;
  localparam logic [3:0] F_MUL  = 4'b1110;
  localparam logic [3:0] F_TEST = 4'b1111;

  // Shift funcs 0000-0011 are the immediate forms (lshi/ashui).
  localparam logic [3:0] SH_LSH  = 4'b0100;
  localparam logic [3:0] SH_ASHU = 4'b0110;

  localparam logic [3:0] SP_LOAD  = 4'b0000;
  localparam logic [3:0] SP_STOR  = 4'b0100;
  localparam logic [3:0] SP_JAL   = 4'b1000;
  localparam logic [3:0] SP_JCOND = 4'b1100;
  localparam logic [3:0] SP_SCOND = 4'b1101;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  typedef struct packed {
    logic [3:0]  rdest;
    logic [15:0] pc;
    logic        wr;
    logic        jal;
    logic        load;
    logic        store;
  } ex_t;

  // Load data arrives through the memory path, so loads are excluded here.
  function automatic logic writes_reg(input logic [3:0] oper, input logic [3:0] func);
    logic w;
    w = 1'b1;
    case (oper)
      OP_CMPI, OP_BCOND: w = 1'b0;
      OP_REG:     w = (func != F_CMP) && (func != F_TEST);
      OP_SPECIAL: w = (func != SP_JCOND) && (func != SP_SCOND) &&
                      (func != SP_STOR) && (func != SP_LOAD);
      default:    w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile16x16.sv
// rtl/regfile16x16.sv - general register file, two async read ports, one sync write port
module regfile16x16 #(
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [15:0]              ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [15:0]              rb_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [15:0]              wdata
);

  logic [15:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue and writeback stage feeding the combinational alu
// Define ALU_ISSUE_BYPASS_EN to forward writeback data instead of stalling on RAW hazards.
module alu_issue import isa_pkg::*; #(
  parameter int         NREGS     = 16,
  parameter logic [4:0] PSR_RESET = 5'b00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [15:0] instr_pc,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_dst,
  output logic [15:0] alu_src,
  output logic [3:0]  alu_oper,
  output logic [3:0]  alu_func,
  output logic [3:0]  alu_cond,
  output logic [4:0]  alu_cond_in,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_cond_out,
  input  logic        alu_cond_wr,
  output logic        ex_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;

  logic [1:0]  state;
  ex_t         ex;
  logic [4:0]  psr;
  logic [3:0]  oper, rdest, func, rsrc;
  logic [15:0] rf_a, rf_b, dst_reg, src_reg;
  logic [15:0] nxt_dst, nxt_src;
  logic [3:0]  nxt_func, nxt_cond;
  logic        wb_en, stall, is_mem, accept;
  logic [15:0] wb_data;

  assign oper  = instr[15:12];
  assign rdest = instr[11:8];
  assign func  = instr[7:4];
  assign rsrc  = instr[3:0];

  regfile16x16 #(.NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset),
    .ra_addr(rdest), .ra_data(rf_a),
    .rb_addr(rsrc),  .rb_data(rf_b),
    .we(wb_en), .waddr(ex.rdest), .wdata(wb_data)
  );

  assign wb_en   = (state == ST_EXEC && ex.wr) || (state == ST_MEM && mem_done && ex.load);
  assign wb_data = (state == ST_MEM) ? mem_rdata : (ex.jal ? ex.pc + 16'd1 : alu_result);

`ifdef ALU_ISSUE_BYPASS_EN
  assign dst_reg = (wb_en && ex.rdest == rdest) ? wb_data : rf_a;
  assign src_reg = (wb_en && ex.rdest == rsrc)  ? wb_data : rf_b;
  assign stall   = 1'b0;
`else
  logic uses_src;
  assign uses_src = (oper == OP_REG) || (oper == OP_SPECIAL) ||
                    (oper == OP_SHIFT && func[3:2] != 2'b00);
  assign dst_reg  = rf_a;
  assign src_reg  = rf_b;
  assign stall    = wb_en && ((oper != OP_BCOND && rdest == ex.rdest) ||
                              (uses_src && rsrc == ex.rdest));
`endif

  assign is_mem      = (oper == OP_SPECIAL) && (func == SP_LOAD || func == SP_STOR);
  assign instr_ready = (state != ST_MEM) && !stall;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    nxt_dst  = (oper == OP_BCOND) ? instr_pc : dst_reg;
    nxt_src  = 16'h0;
    nxt_func = 4'h0;
    nxt_cond = 4'h0;
    case (oper)
      OP_REG: begin
        nxt_src  = src_reg;
        nxt_func = func;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_LUI:
        nxt_src = {8'h00, instr[7:0]};
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_SUBCI, OP_CMPI, OP_MULI, OP_MOVI:
        nxt_src = {{8{instr[7]}}, instr[7:0]};
      OP_BCOND: begin
        nxt_src  = {{8{instr[7]}}, instr[7:0]};
        nxt_cond = rdest;
      end
      OP_SHIFT: begin
        nxt_func = func;
        nxt_src  = (func[3:2] == 2'b00) ? {12'h000, rsrc} : src_reg;
      end
      OP_SPECIAL: begin
        nxt_src  = src_reg;
        nxt_func = func;
        nxt_cond = rdest;
      end
      default: nxt_src = 16'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ex       <= '0;
      psr      <= PSR_RESET;
      alu_dst  <= '0;
      alu_src  <= '0;
      alu_oper <= '0;
      alu_func <= '0;
      alu_cond <= '0;
    end else begin
      if (state == ST_EXEC && alu_cond_wr) psr <= alu_cond_out;
      case (state)
        ST_MEM: if (mem_done) state <= ST_IDLE;
        default: begin
          if (accept) begin
            state    <= is_mem ? ST_MEM : ST_EXEC;
            ex       <= '{rdest: rdest, pc: instr_pc, wr: writes_reg(oper, func),
                          jal: (oper == OP_SPECIAL && func == SP_JAL),
                          load: (oper == OP_SPECIAL && func == SP_LOAD),
                          store: (oper == OP_SPECIAL && func == SP_STOR)};
            alu_dst  <= nxt_dst;
            alu_src  <= nxt_src;
            alu_oper <= oper;
            alu_func <= nxt_func;
            alu_cond <= nxt_cond;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign alu_cond_in = psr;
  assign ex_valid    = (state != ST_IDLE);
  assign mem_req     = (state == ST_MEM);
  assign mem_we      = ex.store;
  assign mem_addr    = alu_src;
  assign mem_wdata   = alu_dst;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed plus random stimulus against an architectural register/PSR model
module tb_alu_issue;
  import isa_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] instr = '0, instr_pc = '0, mem_rdata = '0;
  logic        instr_valid = 1'b0, mem_done = 1'b0;
  logic        instr_ready, ex_valid, mem_req, mem_we, alu_cond_wr;
  logic [15:0] alu_dst, alu_src, alu_result, mem_addr, mem_wdata;
  logic [3:0]  alu_oper, alu_func, alu_cond;
  logic [4:0]  alu_cond_in, alu_cond_out;

  int          tests = 0, failed = 0;
  logic [15:0] rm [16];
  logic [4:0]  psr_m;
  int          prev_rd;
  logic [15:0] rins;
  logic [3:0]  spf [5] = '{SP_LOAD, SP_STOR, SP_JAL, SP_JCOND, SP_SCOND};

  alu_issue dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_dst(alu_dst), .alu_src(alu_src), .alu_oper(alu_oper), .alu_func(alu_func),
    .alu_cond(alu_cond), .alu_cond_in(alu_cond_in), .alu_result(alu_result),
    .alu_cond_out(alu_cond_out), .alu_cond_wr(alu_cond_wr), .ex_valid(ex_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream alu: {cond_wr, cond_out, result}.
  function automatic logic [21:0] alu_fn(input logic [15:0] d, input logic [15:0] s,
                                         input logic [3:0] op, input logic [3:0] fn);
    logic [15:0] r;
    logic [16:0] sum;
    logic        wr;
    sum = {1'b0, d} + {1'b0, s};
    r   = sum[15:0];
    case (op)
      OP_REG: case (fn)
        F_AND: r = d & s;
        F_OR:  r = d | s;
        F_XOR: r = d ^ s;
        F_SUB, F_SUBC, F_CMP: r = d - s;
        F_MOV: r = s;
        F_MUL: r = 16'(d * s);
        default: r = sum[15:0];
      endcase
      OP_ANDI: r = d & s;
      OP_ORI:  r = d | s;
      OP_XORI: r = d ^ s;
      OP_SUBI, OP_SUBCI, OP_CMPI: r = d - s;
      OP_MOVI: r = s;
      OP_MULI: r = 16'(d * s);
      OP_LUI:  r = s << 8;
      OP_SHIFT: r = d << s[3:0];
      default: r = sum[15:0];
    endcase
    wr = (op inside {OP_ADDI, OP_ADDCI, OP_SUBI, OP_SUBCI, OP_CMPI}) ||
         (op == OP_REG && (fn inside {F_ADD, F_ADDC, F_SUB, F_SUBC, F_CMP}));
    return {wr, sum[16], 2'b00, (r == 16'h0), r[15], r};
  endfunction

  assign {alu_cond_wr, alu_cond_out, alu_result} = alu_fn(alu_dst, alu_src, alu_oper, alu_func);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rm[i] = 16'h0;
    psr_m   = 5'b00000;
    prev_rd = -1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    @(negedge clk); #1;
    check("idle_ex_valid", 16'(ex_valid), 16'd0);
    check("idle_mem_req", 16'(mem_req), 16'd0);
    prev_rd = -1;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic issue(input logic [15:0] ins, input logic [15:0] pc, input logic [15:0] rdata);
    logic [3:0]  op, rd, fn, rs, ef, ec;
    logic [15:0] ed, es;
    logic [21:0] ar;
    logic        rsrc_used, st, wr, mem, store;
    op = ins[15:12]; rd = ins[11:8]; fn = ins[7:4]; rs = ins[3:0];
    mem       = (op == OP_SPECIAL) && (fn == SP_LOAD || fn == SP_STOR);
    store     = (op == OP_SPECIAL) && (fn == SP_STOR);
    rsrc_used = (op == OP_REG) || (op == OP_SPECIAL) || (op == OP_SHIFT && fn >= 4'd4);
    st = !BYP && prev_rd >= 0 &&
         ((op != OP_BCOND && int'(rd) == prev_rd) || (rsrc_used && int'(rs) == prev_rd));
    ed = (op == OP_BCOND) ? pc : rm[rd];
    if (rsrc_used) es = rm[rs];
    else if (op == OP_SHIFT) es = 16'(rs);
    else if (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_LUI}) es = 16'(ins[7:0]);
    else es = 16'($signed(ins[7:0]));
    ef = (op == OP_REG || op == OP_SHIFT || op == OP_SPECIAL) ? fn : 4'h0;
    ec = (op == OP_BCOND || op == OP_SPECIAL) ? rd : 4'h0;
    wr = !(op == OP_CMPI || op == OP_BCOND ||
           (op == OP_REG && (fn == F_CMP || fn == F_TEST)) ||
           (op == OP_SPECIAL && (fn inside {SP_JCOND, SP_SCOND, SP_STOR, SP_LOAD})));

    instr = ins; instr_pc = pc; instr_valid = 1'b1;
    #1;
    check("ready", 16'(instr_ready), 16'(!st));
    for (int k = 0; k < 4 && !instr_ready; k++) begin
      @(negedge clk); #1;
    end
    if (st) check("ready_after_stall", 16'(instr_ready), 16'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("alu_dst", alu_dst, ed);
    check("alu_src", alu_src, es);
    check("alu_oper", 16'(alu_oper), 16'(op));
    check("alu_func", 16'(alu_func), 16'(ef));
    check("alu_cond", 16'(alu_cond), 16'(ec));
    check("alu_cond_in", 16'(alu_cond_in), 16'(psr_m));
    check("ex_valid", 16'(ex_valid), 16'd1);
    ar = alu_fn(ed, es, op, ef);
    if (mem) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
        check("mem_req", 16'(mem_req), 16'd1);
        check("mem_ready", 16'(instr_ready), 16'd0);
        check("mem_addr", mem_addr, es);
        check("mem_we", 16'(mem_we), 16'(store));
        if (store) check("mem_wdata", mem_wdata, ed);
      end
      @(negedge clk);
      mem_done = 1'b1; mem_rdata = rdata;
      #1 check("done_ready", 16'(instr_ready), 16'd0);
      @(posedge clk); #1;
      mem_done = 1'b0;
      check("mem_req_drop", 16'(mem_req), 16'd0);
      if (!store) rm[rd] = rdata;
      prev_rd = -1;
    end else begin
      if (wr) rm[rd] = (op == OP_SPECIAL && fn == SP_JAL) ? pc + 16'd1 : ar[15:0];
      if (ar[21]) psr_m = ar[20:16];
      prev_rd = wr ? int'(rd) : -1;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 16'(instr_ready), 16'd1);
    check("rst_ex_valid", 16'(ex_valid), 16'd0);
    check("rst_mem_req", 16'(mem_req), 16'd0);
    check("rst_alu_dst", alu_dst, 16'h0);
    check("rst_alu_oper", 16'(alu_oper), 16'h0);
    check("rst_psr", 16'(alu_cond_in), 16'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    issue(16'hD105, 16'h0010, 16'h0);   // movi R1,#5
    issue(16'hD207, 16'h0011, 16'h0);   // movi R2,#7
    issue(16'h0152, 16'h0012, 16'h0);   // add R1,R2
    issue(16'h53FF, 16'h0013, 16'h0);   // addi R3,#-1
    issue(16'h1480, 16'h0014, 16'h0);   // andi R4,#0x80
    issue(16'h0152, 16'h0015, 16'h0);   // add R1,R2
    issue(16'h0551, 16'h0016, 16'h0);   // add R5,R1 (RAW on R1)
    issue(16'hF701, 16'h0017, 16'h0);   // lui R7,#1
    idle();
    issue(16'h4607, 16'h0018, 16'hBEEF); // load R6,[R7]
    issue(16'h06B6, 16'h0019, 16'h0);   // cmp R6,R6
    issue(16'h4647, 16'h001A, 16'h0);   // stor R6,[R7]
    issue(16'h4880, 16'hFFFF, 16'h0);   // jal R8 from 0xFFFF wraps to 0
    issue(16'h08B8, 16'h0020, 16'h0);   // cmp R8,R8
    issue(16'hC3F0, 16'h1234, 16'h0);   // bcond
    issue(16'h8103, 16'h0021, 16'h0);   // lshi R1,#3
    issue(16'h8142, 16'h0022, 16'h0);   // lsh R1,R2

    for (int n = 0; n < 160; n++) begin
      rins = 16'($urandom);
      if (rins[15:12] == OP_SPECIAL) rins[7:4] = spf[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) idle();
      issue(rins, 16'($urandom), 16'($urandom));
    end

    issue(16'hD300, 16'h0030, 16'h0);   // movi R3,#0
    issue(16'h53FF, 16'h0031, 16'h0);   // addi R3,#-1 sets N
    idle();
    instr = 16'h4607; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_mem_req", 16'(mem_req), 16'd1);
    check("pre_rst_psr", 16'(alu_cond_in), 16'(psr_m));
    #2 reset = 1'b1;
    #1;
    check("async_mem_req", 16'(mem_req), 16'd0);
    check("async_ex_valid", 16'(ex_valid), 16'd0);
    check("async_psr", 16'(alu_cond_in), 16'd0);
    check("async_alu_dst", alu_dst, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    issue(16'hD105, 16'h0040, 16'h0);
    issue(16'h01B1, 16'h0041, 16'h0);
    for (int x = 0; x < 16; x++) issue({4'h0, 4'(x), F_CMP, 4'(x)}, 16'h0050, 16'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
